uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Byte-stream frame parser sitting directly downstream of uart_rx: consumes its (data_out, data_valid) bytes.
//  Hunts for SOF, reads a length byte, buffers the payload, checks an XOR checksum.
//  Presents a validated frame through a read port, held until acknowledged. Errors are reported as a pulse plus a code.
// PARAMETERS
//  MAX_LEN      16        max payload bytes; legal length range 1..MAX_LEN
//  SOF          8'hA5     start-of-frame byte
//  TIMEOUT_CYC  200000    inter-byte gap limit in clk cycles (used only with UART_FRAME_TIMEOUT_EN)
//  LEN_W        localparam $clog2(MAX_LEN+1); ADDR_W = $clog2(MAX_LEN)
// PORTS
//  clk          in   1       system clock, single clock domain
//  rst_n        in   1       synchronous reset, active-low
//  rx_valid     in   1       byte strobe from uart_rx data_valid; back-to-back cycles allowed
//  rx_data      in   8       byte from uart_rx data_out; sampled when rx_valid=1
//  frame_valid  out  1       validated frame available (level)
//  frame_len    out  LEN_W   payload length of the held frame
//  rd_addr      in   ADDR_W  payload read address
//  rd_data      out  8       payload byte at rd_addr, 1-cycle registered latency
//  frame_ack    in   1       consumer releases the held frame
//  frame_err    out  1       1-cycle error pulse
//  err_code     out  2       01=bad length, 10=bad checksum, 11=timeout; holds until next error
//  overrun      out  1       1-cycle pulse: byte dropped while a frame was held
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; counters and checksum cleared. Buffer RAM is not reset.
//  Reset mid-frame aborts the frame silently: no frame_err.
//  FSM states: IDLE, LEN, PAYLOAD, CHK, HOLD.
//  IDLE: rx_valid & rx_data==SOF -> LEN. All other bytes ignored.
//  LEN: on rx_valid, byte L.
//   - L==0 or L>MAX_LEN: frame_err=1 and err_code=01 in the next cycle; -> IDLE.
//   - Otherwise: latch L, chk<=L, wr_ptr<=0; -> PAYLOAD.
//  PAYLOAD: on rx_valid, buf[wr_ptr]<=byte, chk<=chk^byte, wr_ptr++. -> CHK after the byte written at wr_ptr==L-1.
//  CHK: on rx_valid, compare the byte with chk.
//   - Equal: -> HOLD; frame_valid=1 and frame_len=L from the next cycle.
//   - Not equal: frame_err pulse, err_code=10; -> IDLE.
//  HOLD:
//   - frame_valid stays 1; rd_data <= buf[rd_addr] every cycle.
//   - frame_ack=1 -> IDLE; frame_valid drops the next cycle.
//   - rx_valid in HOLD (including the ack cycle): byte dropped, overrun pulse next cycle; frame and err_code unchanged.
//  frame_ack outside HOLD is ignored. rd_data is don't-care outside HOLD.
//  Checksum = XOR of the LEN byte and all payload bytes; 8-bit, no carry.
//  A SOF value inside LEN/PAYLOAD/CHK is treated as data, never as a resync.
//  Throughput: 1 byte/cycle sustained. Latency from checksum byte to frame_valid = 1 cycle.
// CONFIGURATION
//  UART_FRAME_TIMEOUT_EN defined:
//   - Gap counter cleared on every rx_valid; counts only in LEN/PAYLOAD/CHK.
//   - Reaching TIMEOUT_CYC-1 with no rx_valid: frame_err pulse, err_code=11; -> IDLE.
//   - rx_valid in the same cycle as expiry wins; the byte is processed.
//  UART_FRAME_TIMEOUT_EN undefined:
//   - No counter is built; the parser waits indefinitely; code 11 is never produced.
// STRUCTURE
//  uart_frame_pkg:
//   - state_t enum {IDLE, LEN, PAYLOAD, CHK, HOLD}
//   - ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TMO=2'b11
//   - DEFAULT_SOF=8'hA5
//  Sub-module uart_frame_buf: MAX_LEN x 8 simple dual-port RAM; synchronous write, registered read.
//  The parser holds the FSM, checksum, pointers and timeout.
// TESTING
//  1. Good frame: A5 03 11 22 33 03 -> frame_valid=1, frame_len=3; rd_addr 0,1,2 -> rd_data 11,22,33 one cycle later.
//  2. Bad checksum: A5 02 AA 55 00 (expected FD) -> frame_err pulse, err_code=10, frame_valid stays 0.
//  3. Bad length: A5 00, then A5 11 (17 > 16) -> two frame_err pulses, err_code=01; parser back in IDLE.
//  4. Pre-noise, overrun, ack:
//     - 00 FF 5A, then frame 1 -> noise ignored, frame accepted.
//     - Extra byte during HOLD -> overrun pulse, held data unchanged.
//     - frame_ack -> frame_valid=0 next cycle.
//  5. Gap A5 02 AA, then idle TIMEOUT_CYC cycles:
//     - Macro defined: err_code=11, IDLE; a following good frame is accepted.
//     - Macro undefined: no error; sending 55 FD afterwards completes the frame.
//  6. rst_n=0 for 1 cycle mid-PAYLOAD -> all outputs 0, no frame_err; next good frame accepted. Also back-to-back rx_valid every cycle.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser slice.
// Optional inter-byte timeout is enabled with `define UART_FRAME_TIMEOUT_EN.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // A length byte is legal when it names 1..max_len payload bytes.
    function automatic logic len_legal(input logic [7:0] len_byte, input int max_len);
        return (len_byte != 8'd0) && (int'(len_byte) <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write, registered read.
module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/length/payload/XOR-checksum frames from a uart_rx byte stream and holds one frame until acked.
// Define UART_FRAME_TIMEOUT_EN to build the inter-byte gap timeout (TIMEOUT_CYC).
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = DEFAULT_SOF,
    parameter int         TIMEOUT_CYC = 200000,
    localparam int        LEN_W       = $clog2(MAX_LEN + 1),
    localparam int        ADDR_W      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              frame_valid,
    output logic [LEN_W-1:0]  frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              overrun
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [7:0]       chk_q;
    logic             buf_we;
    logic             in_frame;

    assign buf_we   = (state == PAYLOAD) && rx_valid;
    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int GAP_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [GAP_W-1:0] gap_q;
    logic             gap_expired;

    assign gap_expired = (gap_q == GAP_W'(TIMEOUT_CYC - 1));
`endif

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (cnt_q[ADDR_W-1:0]),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: every register here is updated with <=, so all branches see the pre-edge state and later assignments win.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            chk_q       <= 8'h00;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            overrun     <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            gap_q       <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            gap_q     <= '0;
`endif
            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == SOF)) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        if (!len_legal(rx_data, MAX_LEN)) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= IDLE;
                        end else begin
                            len_q <= rx_data[LEN_W-1:0];
                            chk_q <= rx_data;
                            cnt_q <= '0;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        chk_q <= chk_q ^ rx_data;
                        cnt_q <= cnt_q + LEN_ONE;
                        if (cnt_q == len_q - LEN_ONE) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_q) begin
                            frame_valid <= 1'b1;
                            frame_len   <= len_q;
                            state       <= HOLD;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                            state     <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    // Incoming bytes cannot be buffered while the frame is held.
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        frame_len   <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef UART_FRAME_TIMEOUT_EN
            // A byte arriving on the expiry cycle takes priority, so only idle cycles count.
            if (in_frame && !rx_valid) begin
                if (gap_expired) begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_TMO;
                    state     <= IDLE;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus random traffic against a frame-level model.
// Expectations follow UART_FRAME_TIMEOUT_EN when the bench is built with it.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int ADDR_W  = $clog2(MAX_LEN);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              frame_ack = 1'b0;
    logic              frame_valid;
    logic [LEN_W-1:0]  frame_len;
    logic [7:0]        rd_data;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              overrun;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN     (MAX_LEN),
        .SOF         (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .overrun     (overrun)
    );

    typedef enum int {EV_FRAME, EV_ERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
    } ev_t;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level reference model state
    ev_t          sb[$];
    bit           m_in_frame = 1'b0;
    bit           m_held = 1'b0;
    byte unsigned m_col[$];
    byte unsigned m_payload[$];
    int           m_gap = 0;
    int           m_code = 0;
    bit           prev_fv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(input ev_kind_t k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_held     = 1'b0;
        m_gap      = 0;
        m_code     = 0;
        m_col.delete();
    endtask

    // One clock edge of the parser, expressed in terms of collected frame bytes.
    task automatic model_step(input bit v, input byte unsigned d, input bit ack);
        int           len;
        byte unsigned x;
        if (m_held) begin
            if (v) sb.push_back(mk_ev(EV_OVR, 0));
            if (ack) m_held = 1'b0;
            return;
        end
        if (!v) begin
`ifdef UART_FRAME_TIMEOUT_EN
            if (m_in_frame) begin
                m_gap++;
                if (m_gap == TMO) begin
                    sb.push_back(mk_ev(EV_ERR, 3));
                    m_code     = 3;
                    m_in_frame = 1'b0;
                end
            end
`endif
            return;
        end
        m_gap = 0;
        if (!m_in_frame) begin
            if (d == 8'hA5) begin
                m_in_frame = 1'b1;
                m_col.delete();
            end
            return;
        end
        m_col.push_back(d);
        len = int'(m_col[0]);
        if (m_col.size() == 1) begin
            if (len == 0 || len > MAX_LEN) begin
                sb.push_back(mk_ev(EV_ERR, 1));
                m_code     = 1;
                m_in_frame = 1'b0;
            end
        end else if (m_col.size() == len + 2) begin
            x = 8'h00;
            for (int i = 0; i <= len; i++) x = x ^ m_col[i];
            if (x == m_col[len + 1]) begin
                m_payload.delete();
                for (int i = 1; i <= len; i++) m_payload.push_back(m_col[i]);
                sb.push_back(mk_ev(EV_FRAME, len));
                m_held = 1'b1;
            end else begin
                sb.push_back(mk_ev(EV_ERR, 2));
                m_code = 2;
            end
            m_in_frame = 1'b0;
        end
    endtask

    task automatic drive(input bit v, input byte unsigned d, input bit ack);
        rx_valid  = v;
        rx_data   = v ? d : 8'($urandom_range(0, 255));
        frame_ack = ack;
        @(posedge clk);
        model_step(v, d, ack);
        #1;
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input byte unsigned q[$]);
        foreach (q[i]) drive(1'b1, q[i], 1'b0);
    endtask

    task automatic read_at(input int a);
        rd_addr = ADDR_W'(a);
        drive(1'b0, 8'h00, 1'b0);
        check("rd_data", 32'(rd_data), 32'(m_payload[a]));
    endtask

    task automatic read_all();
        for (int i = 0; i < m_payload.size(); i++) read_at(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_frame_len", 32'(frame_len), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_rd_data", 32'(rd_data), 0);
    endtask

    task automatic pop_expect(input ev_kind_t k, input string name, input logic [31:0] got);
        ev_t e;
        if (sb.size() == 0) begin
            check({name, "_unexpected"}, 32'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        check({name, "_kind"}, 32'(e.kind), 32'(k));
        if (k != EV_OVR) check(name, got, 32'(e.val));
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals an event, and tracks level outputs.
    always @(negedge clk) begin
        if (frame_err === 1'b1) pop_expect(EV_ERR, "err_code", 32'(err_code));
        if (overrun === 1'b1) pop_expect(EV_OVR, "overrun", 32'(0));
        if (frame_valid === 1'b1 && !prev_fv) pop_expect(EV_FRAME, "frame_len", 32'(frame_len));
        prev_fv = (frame_valid === 1'b1);
        check("frame_valid_level", 32'(frame_valid), 32'(m_held));
        check("err_code_level", 32'(err_code), 32'(m_code));
    end

    task automatic send_random(input int kind);
        byte unsigned q[$];
        byte unsigned x;
        byte unsigned b;
        int           len;
        case (kind)
            0, 1: begin
                len = $urandom_range(1, MAX_LEN);
                q.push_back(8'hA5);
                q.push_back(8'(len));
                x = 8'(len);
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom_range(0, 255));
                    q.push_back(b);
                    x = x ^ b;
                end
                if (kind == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
                q.push_back(x);
            end
            2: begin
                q.push_back(8'hA5);
                q.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end
            default: begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                    do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
                    q.push_back(b);
                end
            end
        endcase
        foreach (q[i]) begin
            drive(1'b1, q[i], 1'b0);
            if ($urandom_range(0, 3) == 0) drive(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("init_frame_valid", 32'(frame_valid), 0);
        check("init_err_code", 32'(err_code), 0);
        check("init_overrun", 32'(overrun), 0);

        // Good frame, then overrun while held, then ack
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        check("t1_frame_len", 32'(frame_len), 3);
        read_all();
        drive(1'b1, 8'h77, 1'b0);
        read_all();
        drive(1'b0, 8'h00, 1'b1);
        check("t1_valid_after_ack", 32'(frame_valid), 0);

        // Bad checksum
        send('{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00});
        idle(1);
        check("t2_err_code", 32'(err_code), 2);

        // Bad lengths: zero, then one past the maximum
        send('{8'hA5, 8'h00});
        send('{8'hA5, 8'h11});
        idle(1);
        check("t3_err_code", 32'(err_code), 1);

        // Noise, then a good frame; ack arrives together with an extra byte
        send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        read_all();
        drive(1'b1, 8'h12, 1'b1);
        idle(1);

        // Long gap mid-frame, then the rest of the frame
        send('{8'hA5, 8'h02, 8'hAA});
        idle(TMO + 4);
        send('{8'h55, 8'hFD});
        if (m_held) begin
            read_all();
            drive(1'b0, 8'h00, 1'b1);
        end
        send('{8'hA5, 8'h01, 8'hA5, 8'hA4});
        check("t5_frame_len", 32'(frame_len), 1);
        read_all();
        drive(1'b0, 8'h00, 1'b1);

        // Reset in the middle of a payload, then back-to-back frames
        send('{8'hA5, 8'h04, 8'h01, 8'h02});
        do_reset();
        send('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32});
        check("t6_frame_len", 32'(frame_len), 2);
        read_all();
        drive(1'b0, 8'h00, 1'b1);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            send_random($urandom_range(0, 3));
            if (m_held) begin
                read_all();
                if ($urandom_range(0, 1) == 1) begin
                    drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
                    read_at($urandom_range(0, m_payload.size() - 1));
                end
                drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
